vga_bank_swap_scheduler: RTL
============================

Name: vga_bank_swap_scheduler

Overview:
- Controls access to a double-buffered 1-bpp VRAM, two banks of WORDS x 32 bits, inside the TinyQV VGA peripheral.
- The display scans one bank. CPU word writes are routed to the other (back) bank.
- A CPU swap request is deferred to a frame boundary, subject to a minimum frame interval. CPU writes are stalled while a swap is pending.
- Also provides the frame counter and a swap-complete interrupt.

Parameters:
- WORDS, 12, 32-bit words per bank (384 pixels).
- WORD_BITS, 4, width of the word index; must satisfy 2^WORD_BITS >= WORDS.
- FRAME_BITS, 8, width of the frame counter.

Ports:
- clk  in  1  peripheral clock (64 MHz).
- rst_n  in  1  reset. Single clock; reset is asynchronous and active-low.
- frame_start  in  1  one-cycle pulse at the start of vertical blank, from the timing generator.
- swap_req  in  1  one-cycle pulse: CPU requests a bank swap.
- swap_interval  in  4  minimum frames between swaps; 0 is treated as 1.
- irq_en  in  1  enables the swap-complete interrupt.
- cli  in  1  one-cycle pulse that clears irq.
- cpu_wr  in  1  CPU word-write request.
- cpu_word  in  WORD_BITS  target word index.
- cpu_data  in  32  write data.
- cpu_ready  out  1  write accepted this cycle; combinational, equals !swap_pending.
- vram_we  out  1  registered write strobe to the VRAM.
- vram_bank  out  1  bank to be written.
- vram_word  out  WORD_BITS  word index to be written.
- vram_data  out  32  data to be written.
- display_bank  out  1  bank currently scanned out.
- swap_pending  out  1  high while state is PENDING.
- frame_count  out  FRAME_BITS  frames since reset.
- irq  out  1  swap-complete interrupt, level.

Behaviour:
- Reset values (asynchronous): state IDLE, display_bank 0, vram_we 0, vram_bank 0, vram_word 0, vram_data 0, frame_count 0, frames_since_swap 0, irq 0. A request pending at reset is discarded.
- States:
  - IDLE: cpu_ready 1. swap_req moves to PENDING.
  - PENDING: cpu_ready 0. An eligible frame_start executes the swap and returns to IDLE. swap_req is ignored.
- Eligibility: a frame_start is eligible when frames_since_swap >= (interval_eff - 1), where interval_eff = max(swap_interval, 1). swap_interval is sampled at that frame_start.
- Swap execution, all on the eligible frame_start edge:
  - display_bank toggles and frames_since_swap clears to 0.
  - irq sets if irq_en is 1.
  - state returns to IDLE; cpu_ready is 1 from the next cycle.
- frames_since_swap increments on every non-swapping frame_start and saturates at 15.
- frame_count increments on every frame_start and wraps from 2^FRAME_BITS-1 to 0.
- swap_req together with frame_start while in IDLE: go to PENDING; that frame_start does not execute the swap.
- Writes:
  - Accepted when cpu_wr && cpu_ready.
  - Next cycle: vram_we=1, vram_bank=!display_bank (value before the edge), vram_word=cpu_word, vram_data=cpu_data. Latency is 1 cycle.
  - vram_we is 0 in every other cycle; vram_bank/word/data hold their last value.
  - A write with cpu_word >= WORDS is accepted (cpu_ready 1) but discarded: vram_we stays 0.
- Stalled write: when cpu_wr is high and cpu_ready is 0, nothing is written. The requester holds cpu_wr, cpu_word and cpu_data until cpu_ready is 1.
- cpu_wr together with swap_req in IDLE: the write is accepted into the current back bank, then the state goes to PENDING.
- Because writes are blocked in PENDING, no write can land in a bank during the cycle that bank becomes the display bank.
- irq priority: if set and cli fall in the same cycle, set wins. Otherwise cli clears irq. irq_en low does not clear an existing irq.
- frame_start pulses are at least 2 cycles apart. Behaviour for back-to-back pulses is not required.

Test Plan:
- Reset: assert rst_n=0 mid-PENDING with irq=1 -> all outputs at reset values immediately, without waiting for a clk edge. After release, cpu_ready=1 and display_bank=0.
- Basic write: display_bank=0, cpu_wr with cpu_word=5, cpu_data=0xDEADBEEF -> next cycle vram_we=1, vram_bank=1, vram_word=5, vram_data=0xDEADBEEF. The cycle after, vram_we=0. cpu_word=12 -> vram_we stays 0.
- Swap with interval 1: swap_req, then frame_start 10 cycles later, irq_en=1 -> swap_pending=1 and cpu_ready=0 for those 10 cycles. On the frame_start edge display_bank=1, irq=1, swap_pending=0. The next write goes to bank 0.
- Interval 3: swap performed, swap_req issued, then frame_starts -> swap executes on the 3rd frame_start after the previous swap, not earlier. With swap_interval=0 it executes on the 1st.
- Simultaneous events: swap_req with frame_start -> swap on the next frame_start. cpu_wr with swap_req -> write lands in the old back bank. cli with swap execution -> irq=1.
- Stall and hold: cpu_wr held during PENDING with word 2 -> no vram_we while pending. One write is emitted the cycle after cpu_ready returns to 1, into the new back bank. After 256 frame_starts frame_count returns to 0.

Source files
------------

// File: rtl/vga_bank_swap_scheduler.sv
// Double-buffered VRAM bank scheduler for the TinyQV VGA peripheral.
// The display scans one bank while CPU word writes go to the other (back) bank.
// Swap requests wait for an eligible frame boundary, and CPU writes stall while
// a swap is pending. The block also keeps a frame counter and drives a
// swap-complete interrupt.
//
// Handshake: a CPU write is accepted in any cycle where cpu_wr && cpu_ready.
// cpu_ready is combinational and equals !swap_pending. A stalled requester
// holds cpu_wr, cpu_word and cpu_data until cpu_ready returns high.
module vga_bank_swap_scheduler #(
  parameter int WORDS      = 12,
  parameter int WORD_BITS  = 4,
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  swap_req,
  input  logic [3:0]            swap_interval,
  input  logic                  irq_en,
  input  logic                  cli,
  input  logic                  cpu_wr,
  input  logic [WORD_BITS-1:0]  cpu_word,
  input  logic [31:0]           cpu_data,
  output logic                  cpu_ready,
  output logic                  vram_we,
  output logic                  vram_bank,
  output logic [WORD_BITS-1:0]  vram_word,
  output logic [31:0]           vram_data,
  output logic                  display_bank,
  output logic                  swap_pending,
  output logic [FRAME_BITS-1:0] frame_count,
  output logic                  irq
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // WORDS is widened by one bit so the range check holds even when
  // WORDS == 2**WORD_BITS.
  localparam logic [WORD_BITS:0] WORDS_L = WORDS[WORD_BITS:0];

  state_t      state, state_nxt;
  logic [3:0]  frames_since_swap;
  logic [3:0]  interval_m1;
  logic        eligible;
  logic        do_swap;
  logic        wr_accept;

  // Current state is visible to the outside as swap_pending.
  assign swap_pending = (state == PENDING);
  assign cpu_ready    = !swap_pending;

  // An interval of 0 behaves as 1, so the threshold never goes below zero.
  assign interval_m1 = (swap_interval == 4'd0) ? 4'd0 : (swap_interval - 4'd1);
  assign eligible    = (frames_since_swap >= interval_m1);
  assign do_swap     = swap_pending && frame_start && eligible;

  // Writes to out-of-range words are accepted at the handshake but not emitted.
  assign wr_accept = cpu_wr && cpu_ready && ({1'b0, cpu_word} < WORDS_L);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. swap_req is ignored while a swap is already pending.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (swap_req) state_nxt = PENDING;
      PENDING: if (do_swap)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Display bank toggles and the interval counter restarts on each swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_bank      <= 1'b0;
      frames_since_swap <= 4'd0;
    end else if (do_swap) begin
      display_bank      <= !display_bank;
      frames_since_swap <= 4'd0;
    end else if (frame_start && (frames_since_swap != 4'd15)) begin
      frames_since_swap <= frames_since_swap + 4'd1;
    end
  end

  // Free-running frame counter, wrapping at its full width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           frame_count <= '0;
    else if (frame_start) frame_count <= frame_count + 1'b1;
  end

  // Swap-complete interrupt. A set in the same cycle as cli takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                irq <= 1'b0;
    else if (do_swap && irq_en) irq <= 1'b1;
    else if (cli)              irq <= 1'b0;
  end

  // Registered VRAM write port, pointing at the back bank as it was before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_we   <= 1'b0;
      vram_bank <= 1'b0;
      vram_word <= '0;
      vram_data <= '0;
    end else begin
      vram_we <= wr_accept;
      if (wr_accept) begin
        vram_bank <= !display_bank;
        vram_word <= cpu_word;
        vram_data <= cpu_data;
      end
    end
  end

endmodule
